// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick round-robin scheduler.
//   state_t       : scheduler FSM states (IDLE, RUN, GRANT, WAIT)
//   DIV_RESET_DEF : default divisor after reset
//   OVR_W         : width of the saturating overrun counter
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GRANT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int unsigned DIV_RESET_DEF = 3;
  localparam int unsigned OVR_W         = 8;

endpackage

// File: rtl/tick_divider.sv
// Programmable divide-by-N counter producing the service-slot tick.
// Ports:
//   clk, reset     clock (rising edge) / asynchronous active-high reset
//   i_active       scheduler is out of IDLE; gates the tick output
//   i_run          counter advances this cycle; when low the count returns to 0
//   i_div_load     1-cycle strobe: load i_div_value (0 is treated as 1), restart count
//   i_div_value    new divisor
//   o_tick         high in the cycle where cnt == div_q-1 while active
module tick_divider
  import tick_sched_pkg::*;
#(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned DIV_RESET = DIV_RESET_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_active,
  input  logic             i_run,
  input  logic             i_div_load,
  input  logic [DIV_W-1:0] i_div_value,
  output logic             o_tick
);

  localparam int unsigned DIV_INIT = (DIV_RESET == 0) ? 1 : DIV_RESET;

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_q;
  logic             w_last;

  assign w_last = (r_cnt == r_div_q - 1'b1);
  assign o_tick = i_active & w_last;

  // A load restarts the period; the tick of the load cycle is still based on the old count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_div_q <= DIV_W'(DIV_INIT);
    end else if (i_div_load) begin
      r_cnt   <= '0;
      r_div_q <= (i_div_value == '0) ? DIV_W'(1) : i_div_value;
    end else if (!i_run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_rr_scheduler.sv
// Divide-by-N tick generator with a round-robin slot scheduler. Each tick is a
// service slot handed to one requester, which must answer with done before the
// next grant can be issued.
// Optional feature: define TICK_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// (slot abandoned after TIMEOUT_CYC cycles, sticky timeout_err).
// Ports:
//   clk, reset   clock (rising edge) / asynchronous active-high reset
//   enable       run request; 0 stops counting (after any open handshake)
//   div_load     1-cycle strobe to load div_value (0 treated as 1)
//   div_value    new divisor
//   req          per-client request level, sampled only in the tick cycle
//   done         granted client finished its slot (only observed in WAIT)
//   tick         1-cycle slot tick
//   grant        one-hot 1-cycle grant pulse
//   grant_idx    index of the last grant, held
//   busy         GRANT or WAIT
//   overrun_cnt  ticks seen while busy, saturating
//   timeout_err  sticky watchdog flag (tied 0 without the macro)
module tick_rr_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_RESET   = DIV_RESET_DEF,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       div_load,
  input  logic [DIV_W-1:0]           div_value,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       done,
  output logic                       tick,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       busy,
  output logic [OVR_W-1:0]           overrun_cnt,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_last_idx;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;
  logic             w_hi_found;
  logic             w_lo_found;
  logic             w_tick;
  logic             w_take;
  logic             w_active;
  logic             w_run;
  logic             w_timeout;
  logic [OVR_W-1:0] r_ovr;

  assign w_active = (r_state != IDLE);
  // Count only while staying out of IDLE, so the count is 0 on every RUN entry.
  assign w_run    = w_active && (w_next != IDLE);
  assign w_take   = (r_state == RUN) && w_tick && (|req);

  tick_divider #(
    .DIV_W     (DIV_W),
    .DIV_RESET (DIV_RESET)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_active    (w_active),
    .i_run       (w_run),
    .i_div_load  (div_load),
    .i_div_value (div_value),
    .o_tick      (w_tick)
  );

  // Round-robin: lowest requester above last_idx, else lowest at or below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (IDX_W'(i) > r_last_idx) begin
          if (!w_hi_found) begin
            w_hi_found = 1'b1;
            w_hi_idx   = IDX_W'(i);
          end
        end else if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDX_W'(i);
        end
      end
    end
    w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (enable) w_next = RUN;
      RUN: begin
        if (w_take)       w_next = GRANT;
        else if (!enable) w_next = IDLE;
      end
      GRANT:   w_next = WAIT;
      WAIT:    if (done || w_timeout) w_next = enable ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (r_state == GRANT) grant[r_grant_idx] = 1'b1;
    busy        = (r_state == GRANT) || (r_state == WAIT);
    tick        = w_tick;
    grant_idx   = r_grant_idx;
    overrun_cnt = r_ovr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_idx  <= IDX_W'(NUM_REQ - 1);
      r_grant_idx <= '0;
    end else if (w_take) begin
      r_last_idx  <= w_winner;
      r_grant_idx <= w_winner;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_ovr <= '0;
    else if (w_tick && busy && r_ovr != '1) r_ovr <= r_ovr + 1'b1;
  end

`ifdef TICK_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout_err;

  // r_wd is 0 in the first WAIT cycle, so the limit hits on WAIT cycle TIMEOUT_CYC.
  assign w_timeout   = (r_state == WAIT) && !done && (r_wd == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wd <= (r_state == WAIT) ? r_wd + 1'b1 : '0;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout            = 1'b0;
  assign timeout_err          = 1'b0;
`endif

endmodule

// File: tb/tb_tick_rr_scheduler.sv
// Self-checking bench for tick_rr_scheduler: directed scenarios followed by a
// randomized phase, all checked every cycle against a slot-level reference model.
module tb_tick_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          div_load;
  logic [DW-1:0] div_value;
  logic [N-1:0]  req;
  logic          done;
  logic          tick;
  logic [N-1:0]  grant;
  logic [1:0]    grant_idx;
  logic          busy;
  logic [7:0]    overrun_cnt;
  logic          timeout_err;

  tick_rr_scheduler #(
    .NUM_REQ     (N),
    .DIV_W       (DW),
    .DIV_RESET   (3),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_load    (div_load),
    .div_value   (div_value),
    .req         (req),
    .done        (done),
    .tick        (tick),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: time-stamped view of the schedule.
  int c;           // cycle number
  bit m_active;    // counting (not idle)
  bit m_slot;      // a slot is open (grant issued, done not yet seen)
  int m_base;      // cycle in which the count was last at 0
  int m_div;
  int m_last;
  int m_gidx;
  int m_ovr;
  int m_grant_at;  // cycle of the grant pulse for the open slot
  bit m_err;
  int done_dly;    // done asserted once WAIT age exceeds this; -1 = never
  bit done_noise;  // random done outside WAIT

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    logic [N-1:0] rr;
    rr = r;
    for (int k = 1; k <= N; k++)
      if (rr[(last + k) % N]) return (last + k) % N;
    return last;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_slot     = 1'b0;
    m_base     = 0;
    m_div      = 3;
    m_last     = N - 1;
    m_gidx     = 0;
    m_ovr      = 0;
    m_grant_at = 0;
    m_err      = 1'b0;
  endtask

  // Called just after a rising edge: drives done, checks at the falling edge,
  // advances the model with the current inputs, returns just after the next rising edge.
  task automatic step();
    bit e_tick;
    int e_grant;
    int age;
    bit leave;
    age = c - m_grant_at;
    if (m_slot && age >= 1) done = (done_dly >= 0) && (age > done_dly);
    else                    done = done_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    e_tick  = m_active && (((c - m_base) % m_div) == m_div - 1);
    e_grant = (m_slot && c == m_grant_at) ? (1 << m_gidx) : 0;
    chk("tick",        32'(tick),        32'(e_tick));
    chk("grant",       32'(grant),       32'(e_grant));
    chk("grant_idx",   32'(grant_idx),   32'(m_gidx));
    chk("busy",        32'(busy),        32'(m_slot));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));

    if (e_tick && m_slot && m_ovr < 255) m_ovr++;
    if (!m_active) begin
      if (enable) begin
        m_active = 1'b1;
        m_base   = c + 1;
      end
    end else if (!m_slot) begin
      if (e_tick && req != '0) begin
        m_gidx     = rr_pick(m_last, req);
        m_last     = m_gidx;
        m_slot     = 1'b1;
        m_grant_at = c + 1;
      end else if (!enable) begin
        m_active = 1'b0;
      end
    end else if (c != m_grant_at) begin
      leave = done;
`ifdef TICK_SCHED_TIMEOUT_EN
      if (!done && (c - m_grant_at) == TO) begin
        leave = 1'b1;
        m_err = 1'b1;
      end
`endif
      if (leave) begin
        m_slot = 1'b0;
        if (!enable) m_active = 1'b0;
      end
    end
    if (div_load) begin
      m_div  = (div_value == '0) ? 1 : int'(div_value);
      m_base = c + 1;
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  int ovr_base;

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    div_load   = 1'b0;
    div_value  = '0;
    req        = '0;
    done       = 1'b0;
    done_dly   = 0;
    done_noise = 1'b0;
    c          = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();                         // outputs during reset
    reset = 1'b0;

    // 1: single requester, done one cycle after grant
    enable = 1'b1;
    req    = 4'b0001;
    repeat (16) step();

    // 2: all requesting, immediate done -> rotating grants
    req = 4'b1111;
    repeat (20) step();

    // 4: done withheld, overruns counted while busy
    req      = 4'b0010;
    done_dly = 9;
    for (int k = 0; k < 10 && !m_slot; k++) step();
    chk("slot_opened", 32'(busy), 32'd1);
    ovr_base = m_ovr;
    for (int k = 0; k < 30 && m_slot; k++) step();
    chk("slot_closed", 32'(busy), 32'd0);
    chk("overrun_delta", 32'(overrun_cnt), 32'(ovr_base + 3));
    req      = '0;
    done_dly = 0;
    repeat (4) step();

    // 3: divisor 5, then 0 (treated as 1)
    div_value = 8'd5;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;
    repeat (15) step();
    div_value = 8'd0;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;
    repeat (6) step();
    req = 4'b0100;
    repeat (12) step();
    div_value = 8'd3;
    div_load  = 1'b1;
    step();
    div_load = 1'b0;

    // 5: asynchronous reset while waiting for done
    req      = 4'b1111;
    done_dly = -1;
    for (int k = 0; k < 20 && !(m_slot && c > m_grant_at); k++) step();
    chk("in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_tick",  32'(tick),  32'd0);
    model_reset();
    #1;
    reset    = 1'b0;
    done_dly = 0;
    for (int k = 0; k < 10 && !m_slot; k++) step();
    chk("grant_idx_after_reset", 32'(grant_idx), 32'd0);
    repeat (4) step();

    // 6: done never arrives
    req      = 4'b0001;
    done_dly = -1;
    for (int k = 0; k < 10 && !m_slot; k++) step();
    req = '0;
    repeat (80) step();
`ifdef TICK_SCHED_TIMEOUT_EN
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
`else
    chk("wait_unbounded", 32'(busy), 32'd1);
`endif
    done_dly = 0;
    repeat (4) step();

    // Randomized traffic
    done_noise = 1'b1;
    repeat (400) begin
      enable    = ($urandom_range(0, 9) != 0);
      req       = 4'($urandom);
      div_load  = ($urandom_range(0, 19) == 0);
      div_value = 8'($urandom_range(0, 6));
      if (!m_slot) done_dly = $urandom_range(0, 4);
      step();
    end
    div_load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
